// File: rtl/score_keeper_pkg.sv
// Shared game package: screen geometry, score width, FSM state type and a
// saturating score increment helper.
package score_keeper_pkg;

  localparam int X_POS_W = 11;
  localparam int SCORE_W = 4;

  localparam logic [X_POS_W-1:0] SCREEN_BORDER = X_POS_W'(8);
  localparam logic [X_POS_W-1:0] SCREEN_H_RES  = X_POS_W'(640);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLAY  = 2'd1,
    PAUSE = 2'd2,
    OVER  = 2'd3
  } game_state_t;

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
    return (s == {SCORE_W{1'b1}}) ? s : s + 1'b1;
  endfunction

endpackage

// File: rtl/score_keeper.sv
// Pong score keeper: detects ball exits once per frame, counts points, holds
// the ball during the post-point pause and declares a winner.
module score_keeper
  import score_keeper_pkg::*;
#(
  parameter int WIN_SCORE    = 9,
  parameter int PAUSE_FRAMES = 60
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               new_frame_i,
  input  logic [X_POS_W-1:0] ball_x_i,
  input  logic               start_i,
  output logic [SCORE_W-1:0] player_score_o,
  output logic [SCORE_W-1:0] enemy_score_o,
  output game_state_t        state_o,
  output logic               hold_o,
  output logic               winner_o
);

  localparam int                 CNT_W    = $clog2(PAUSE_FRAMES + 1);
  localparam logic [CNT_W-1:0]   CNT_LOAD = CNT_W'(PAUSE_FRAMES - 1);
  localparam logic [SCORE_W-1:0] WIN_VAL  = SCORE_W'(WIN_SCORE);

  game_state_t        state_q, state_d;
  logic [SCORE_W-1:0] player_q, player_d;
  logic [SCORE_W-1:0] enemy_q, enemy_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               out_prev_q, out_prev_d;
  logic               winner_q, winner_d;
  logic               hold_q, hold_d;

  logic               out_left, out_right, out_now, point;
  logic [SCORE_W-1:0] player_inc, enemy_inc;

  assign out_left   = ball_x_i < SCREEN_BORDER;
  assign out_right  = ball_x_i > SCREEN_H_RES;
  assign out_now    = out_left | out_right;
  // Rising edge of "out" so a ball lingering off-screen scores only once.
  assign point      = out_now & ~out_prev_q;
  assign player_inc = sat_inc(player_q);
  assign enemy_inc  = sat_inc(enemy_q);

  always_comb begin
    state_d    = state_q;
    player_d   = player_q;
    enemy_d    = enemy_q;
    cnt_d      = cnt_q;
    out_prev_d = out_prev_q;
    winner_d   = winner_q;

    if (new_frame_i) begin
      out_prev_d = out_now;
      case (state_q)
        IDLE, OVER: begin
          if (start_i) begin
            player_d = '0;
            enemy_d  = '0;
            state_d  = PLAY;
          end
        end
        PLAY: begin
          if (point) begin
            cnt_d   = CNT_LOAD;
            state_d = PAUSE;
            if (out_right) begin
              enemy_d = enemy_inc;
              if (enemy_inc == WIN_VAL) begin
                state_d  = OVER;
                winner_d = 1'b0;
              end
            end else begin
              player_d = player_inc;
              if (player_inc == WIN_VAL) begin
                state_d  = OVER;
                winner_d = 1'b1;
              end
            end
          end
        end
        PAUSE: begin
          if (cnt_q == '0) state_d = PLAY;
          else             cnt_d   = cnt_q - 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end

    hold_d = (state_d != PLAY);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      player_q   <= '0;
      enemy_q    <= '0;
      cnt_q      <= '0;
      out_prev_q <= 1'b0;
      winner_q   <= 1'b0;
      hold_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      player_q   <= player_d;
      enemy_q    <= enemy_d;
      cnt_q      <= cnt_d;
      out_prev_q <= out_prev_d;
      winner_q   <= winner_d;
      hold_q     <= hold_d;
    end
  end

  assign player_score_o = player_q;
  assign enemy_score_o  = enemy_q;
  assign state_o        = state_q;
  assign hold_o         = hold_q;
  assign winner_o       = winner_q;

endmodule

// File: tb/tb_score_keeper.sv
// Directed bench for score_keeper with WIN_SCORE=9, PAUSE_FRAMES=4.
module tb_score_keeper;
  import score_keeper_pkg::*;

  logic               clk_i = 1'b0;
  logic               rst_i = 1'b1;
  logic               new_frame_i = 1'b0;
  logic [X_POS_W-1:0] ball_x_i = X_POS_W'(320);
  logic               start_i = 1'b0;
  logic [SCORE_W-1:0] player_score_o;
  logic [SCORE_W-1:0] enemy_score_o;
  game_state_t        state_o;
  logic               hold_o;
  logic               winner_o;

  int n_cmp = 0;
  int n_err = 0;

  localparam int S_IDLE = 0, S_PLAY = 1, S_PAUSE = 2, S_OVER = 3;

  score_keeper #(.WIN_SCORE(9), .PAUSE_FRAMES(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .new_frame_i(new_frame_i),
    .ball_x_i(ball_x_i), .start_i(start_i),
    .player_score_o(player_score_o), .enemy_score_o(enemy_score_o),
    .state_o(state_o), .hold_o(hold_o), .winner_o(winner_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int st, input int ps,
                         input int es, input int hd);
    chk({tag, ".state"}, int'(state_o), st);
    chk({tag, ".player"}, int'(player_score_o), ps);
    chk({tag, ".enemy"}, int'(enemy_score_o), es);
    chk({tag, ".hold"}, int'(hold_o), hd);
  endtask

  // One-cycle strobe driven between edges; returns on the following negedge.
  task automatic strobe(input int x);
    @(negedge clk_i);
    ball_x_i    = X_POS_W'(x);
    new_frame_i = 1'b1;
    @(negedge clk_i);
    new_frame_i = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  initial begin
    repeat (3) @(negedge clk_i);
    chk_all("reset", S_IDLE, 0, 0, 1);
    chk("reset.winner", int'(winner_o), 0);
    rst_i = 1'b0;

    strobe(320);
    chk_all("idle_no_start", S_IDLE, 0, 0, 1);

    start_i = 1'b1;
    strobe(320);
    start_i = 1'b0;
    chk_all("start", S_PLAY, 0, 0, 0);

    // Ball held off the right edge for three strobes scores once.
    strobe(645);
    chk_all("right_exit1", S_PAUSE, 0, 1, 1);
    strobe(645);
    strobe(645);
    chk_all("right_exit3", S_PAUSE, 0, 1, 1);
    strobe(320);
    chk_all("pause_3rd", S_PAUSE, 0, 1, 1);
    idle_cycles(5);
    chk_all("pause_no_strobe", S_PAUSE, 0, 1, 1);
    strobe(320);
    chk_all("pause_done", S_PLAY, 0, 1, 0);

    // Nine player points off the left edge.
    for (int i = 0; i < 9; i++) begin
      strobe(0);
      chk("left_exit.player", int'(player_score_o), i + 1);
      if (i < 8) begin
        chk("left_exit.state", int'(state_o), S_PAUSE);
        repeat (3) strobe(320);
        chk("left_pause.state", int'(state_o), S_PAUSE);
        strobe(320);
        chk("left_resume.state", int'(state_o), S_PLAY);
      end
    end
    chk_all("win", S_OVER, 9, 1, 1);
    chk("win.winner", int'(winner_o), 1);

    strobe(320);
    strobe(0);
    strobe(700);
    chk_all("over_frozen", S_OVER, 9, 1, 1);
    chk("over_frozen.winner", int'(winner_o), 1);

    start_i = 1'b1;
    idle_cycles(3);
    chk_all("over_start_no_strobe", S_OVER, 9, 1, 1);
    strobe(700);
    start_i = 1'b0;
    chk_all("restart", S_PLAY, 0, 0, 0);

    // Ball already out on the restart strobe: no edge, no point.
    strobe(700);
    chk_all("still_out", S_PLAY, 0, 0, 0);
    strobe(320);
    strobe(640);
    chk_all("at_h_res", S_PLAY, 0, 0, 0);
    strobe(8);
    chk_all("at_border", S_PLAY, 0, 0, 0);
    strobe(641);
    chk_all("h_res_plus1", S_PAUSE, 0, 1, 1);
    strobe(320);
    strobe(7);
    chk_all("pause_ignores_exit", S_PAUSE, 0, 1, 1);

    // Asynchronous reset between edges during PAUSE.
    @(negedge clk_i);
    #2 rst_i = 1'b1;
    #1;
    chk_all("async_reset", S_IDLE, 0, 0, 1);
    chk("async_reset.winner", int'(winner_o), 0);
    @(negedge clk_i);
    rst_i = 1'b0;
    strobe(320);
    chk_all("post_reset_idle", S_IDLE, 0, 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
